thread_regfile: RTL and testbench
=================================

// Module: thread_regfile
// PURPOSE
//   Per-thread register file, parametrised successor of the fixed 16x8 file: generic register
//   count and data width, and decoupled load writeback with per-register busy scoreboard.
//   One instance per thread inside each compute core, between decoder, ALU/LSU and scheduler.
//   Top three registers are read-only: %blockIdx, %blockDim, %threadIdx.
// PARAMETERS
//   NUM_REGS          16   total registers, >= 4; writable R0..R(NUM_REGS-4)
//   DATA_BITS         8    register and operand width
//   THREADS_PER_BLOCK 4    reset value of R(NUM_REGS-2) (%blockDim)
//   THREAD_ID         0    reset value of R(NUM_REGS-1) (%threadIdx)
//   ADDR_BITS         $clog2(NUM_REGS)  register address width (derived)
// PORTS
//   clk                       in   1          clock, rising edge
//   reset                     in   1          synchronous, active-high
//   enable                    in   1          thread active in current block
//   block_id                  in   8          current block index -> R(NUM_REGS-3)
//   core_state                in   3          core FSM state; 3'b011 REQUEST, 3'b110 UPDATE
//   decoded_reg_write_enable  in   1          instruction writes rd
//   decoded_reg_input_mux     in   2          00 ARITHMETIC, 01 MEMORY, 10 CONSTANT, 11 DEFERRED
//   decoded_rd_address        in   ADDR_BITS  destination register
//   decoded_rs_address        in   ADDR_BITS  source 1
//   decoded_rt_address        in   ADDR_BITS  source 2
//   decoded_immediate         in   DATA_BITS  CONSTANT source
//   alu_out                   in   DATA_BITS  ARITHMETIC source
//   lsu_out                   in   DATA_BITS  MEMORY source
//   wb_valid                  in   1          deferred load result valid
//   wb_ready                  out  1          writeback accepted this cycle
//   wb_rd                     in   ADDR_BITS  writeback destination
//   wb_data                   in   DATA_BITS  writeback data
//   rs, rt                    out  DATA_BITS  registered operands
//   hazard                    out  1          decoded rs/rt/rd busy (combinational)
// BEHAVIOUR
//   - Reset: all regs 0 except R(NUM_REGS-2)=THREADS_PER_BLOCK, R(NUM_REGS-1)=THREAD_ID;
//     rs=rt=0; all busy bits 0. Reset mid-load discards pending writeback and busy state.
//   - enable=0: no state change, wb_ready=0, hazard=0; rs/rt hold.
//   - enable=1: R(NUM_REGS-3) <= block_id every cycle.
//   - REQUEST: rs/rt <= reg[addr], 1-cycle latency; if wb write accepted same cycle to that
//     address, rs/rt take wb_data (forwarding).
//   - UPDATE with write_enable and rd writable: mux 00/01/10 write alu_out/lsu_out/immediate
//     and clear busy[rd]; mux 11 sets busy[rd], data unchanged. rd read-only -> ignored.
//   - Writeback: wb_ready = enable & ~(core_state==UPDATE & write_enable & rd==wb_rd).
//     Accept when wb_valid & wb_ready: reg[wb_rd] <= wb_data, busy[wb_rd] <= 0.
//     wb_rd read-only -> accepted, dropped. Different-address UPDATE + wb: both commit.
//   - hazard = enable & (busy[rs] | busy[rt] | busy[rd]); scheduler stalls REQUEST on it.
//   - Out-of-range addresses (>= NUM_REGS, non-power-of-2 counts): read 0, writes ignored.
// CONFIGURATION
//   REGFILE_ZERO_REG_EN defined: R0 hard-wired 0; reads return 0, writes/writebacks to R0
//     ignored, busy[0] never set, R0 never causes hazard.
//   Undefined: R0 ordinary writable register.
// TESTING
//   - reset, THREADS_PER_BLOCK=4, THREAD_ID=2, block_id=5, REQUEST rs=13,rt=15 -> rs=5, rt=2
//   - UPDATE CONSTANT rd=3 imm=8'h2A, then REQUEST rs=3 -> rs=8'h2A next cycle
//   - UPDATE rd=14 ARITHMETIC alu_out=8'hFF -> R14 stays 4
//   - UPDATE DEFERRED rd=4 -> hazard=1 for rs=4; wb_valid rd=4 data=8'h77 -> hazard=0, R4=8'h77
//   - REQUEST rs=4 with accepted wb rd=4 data=8'h11 same cycle -> rs=8'h11
//   - UPDATE ARITHMETIC rd=6 with wb_valid rd=6 -> wb_ready=0; next cycle wb accepted, R6=wb_data
//   - REGFILE_ZERO_REG_EN: UPDATE CONSTANT rd=0 imm=9 -> REQUEST rs=0 returns 0

Source files
------------

// File: rtl/thread_regfile_if.sv
// ---------------------------------------------------------------------------
// thread_regfile_if
//   Bundles every signal exchanged between a per-thread register file and the
//   core around it: decoder fields, ALU/LSU results, the deferred-load
//   writeback handshake and the operand/hazard outputs.
//
//   Parameters
//     ADDR_BITS  register address width
//     DATA_BITS  register / operand width
//
//   Modports
//     master  core side (decoder, ALU, LSU, scheduler): drives the controls,
//             the data sources and wb_*; sees wb_ready, rs, rt and hazard.
//     slave   register file side: the mirror image of master.
// ---------------------------------------------------------------------------
interface thread_regfile_if #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
);
    logic                 enable;
    logic [7:0]           block_id;
    logic [2:0]           core_state;
    logic                 decoded_reg_write_enable;
    logic [1:0]           decoded_reg_input_mux;
    logic [ADDR_BITS-1:0] decoded_rd_address;
    logic [ADDR_BITS-1:0] decoded_rs_address;
    logic [ADDR_BITS-1:0] decoded_rt_address;
    logic [DATA_BITS-1:0] decoded_immediate;
    logic [DATA_BITS-1:0] alu_out;
    logic [DATA_BITS-1:0] lsu_out;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [ADDR_BITS-1:0] wb_rd;
    logic [DATA_BITS-1:0] wb_data;
    logic [DATA_BITS-1:0] rs;
    logic [DATA_BITS-1:0] rt;
    logic                 hazard;

    modport master (
        output enable, block_id, core_state,
        output decoded_reg_write_enable, decoded_reg_input_mux,
        output decoded_rd_address, decoded_rs_address, decoded_rt_address,
        output decoded_immediate, alu_out, lsu_out,
        output wb_valid, wb_rd, wb_data,
        input  wb_ready, rs, rt, hazard
    );

    modport slave (
        input  enable, block_id, core_state,
        input  decoded_reg_write_enable, decoded_reg_input_mux,
        input  decoded_rd_address, decoded_rs_address, decoded_rt_address,
        input  decoded_immediate, alu_out, lsu_out,
        input  wb_valid, wb_rd, wb_data,
        output wb_ready, rs, rt, hazard
    );
endinterface

// File: rtl/thread_regfile.sv
// ---------------------------------------------------------------------------
// thread_regfile
//   Per-thread register file with a decoupled load-writeback port and a
//   per-register busy scoreboard. The top three registers are read-only:
//   R(NUM_REGS-3)=%blockIdx (tracks block_id while enabled),
//   R(NUM_REGS-2)=%blockDim, R(NUM_REGS-1)=%threadIdx.
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    thread_regfile_if.slave: decoder fields, ALU/LSU results,
//            writeback handshake (wb_valid/wb_ready/wb_rd/wb_data),
//            registered operands rs/rt and the combinational hazard flag.
//
//   Optional build macro
//     REGFILE_ZERO_REG_EN  R0 hard-wired to zero: never written, never busy.
// ---------------------------------------------------------------------------
module thread_regfile #(
    parameter int NUM_REGS          = 16,
    parameter int DATA_BITS         = 8,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int ADDR_BITS         = $clog2(NUM_REGS)
) (
    input logic             clk,
    input logic             reset,
    thread_regfile_if.slave bus
);
    // The array spans the full address space; slots at or above NUM_REGS are
    // never writable, so they stay at their reset value of zero and reads of
    // out-of-range addresses naturally return 0 without any range compare.
    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [2:0] STATE_REQUEST = 3'b011;
    localparam logic [2:0] STATE_UPDATE  = 3'b110;

    localparam logic [1:0] MUX_ARITHMETIC = 2'b00;
    localparam logic [1:0] MUX_MEMORY     = 2'b01;
    localparam logic [1:0] MUX_DEFERRED   = 2'b11;

    logic [DATA_BITS-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]     busy_reg;
    logic [DATA_BITS-1:0] rs_reg;
    logic [DATA_BITS-1:0] rt_reg;

    logic [DEPTH-1:0]     writable;
    logic                 update_we;
    logic                 upd_write;
    logic                 upd_defer;
    logic                 wb_ready_int;
    logic                 wb_we;
    logic                 hazard_int;
    logic [DATA_BITS-1:0] upd_data;

    // Per-address write permission, fixed at elaboration.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_writable
`ifdef REGFILE_ZERO_REG_EN
            assign writable[gi] = (gi != 0) && (gi <= NUM_REGS - 4);
`else
            assign writable[gi] = (gi <= NUM_REGS - 4);
`endif
        end
    endgenerate

    always_comb begin
        update_we = (bus.core_state == STATE_UPDATE) && bus.decoded_reg_write_enable;

        // An UPDATE to the same destination owns the write port this cycle;
        // the load result waits a cycle so the two never collide.
        wb_ready_int = bus.enable && !(update_we && (bus.decoded_rd_address == bus.wb_rd));

        // Accepted writebacks to read-only addresses are consumed but dropped.
        wb_we = bus.wb_valid && wb_ready_int && writable[bus.wb_rd];

        upd_write = bus.enable && update_we && writable[bus.decoded_rd_address]
                    && (bus.decoded_reg_input_mux != MUX_DEFERRED);
        upd_defer = bus.enable && update_we && writable[bus.decoded_rd_address]
                    && (bus.decoded_reg_input_mux == MUX_DEFERRED);

        case (bus.decoded_reg_input_mux)
            MUX_ARITHMETIC: upd_data = bus.alu_out;
            MUX_MEMORY:     upd_data = bus.lsu_out;
            default:        upd_data = bus.decoded_immediate;
        endcase

        hazard_int = bus.enable && (busy_reg[bus.decoded_rs_address]
                                  || busy_reg[bus.decoded_rt_address]
                                  || busy_reg[bus.decoded_rd_address]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            regs_reg[NUM_REGS-2] <= DATA_BITS'(THREADS_PER_BLOCK);
            regs_reg[NUM_REGS-1] <= DATA_BITS'(THREAD_ID);
            busy_reg <= '0;
            rs_reg   <= '0;
            rt_reg   <= '0;
        end else if (bus.enable) begin
            // Operand fetch sees a same-cycle writeback to its address.
            if (bus.core_state == STATE_REQUEST) begin
                rs_reg <= (wb_we && (bus.wb_rd == bus.decoded_rs_address))
                          ? bus.wb_data : regs_reg[bus.decoded_rs_address];
                rt_reg <= (wb_we && (bus.wb_rd == bus.decoded_rt_address))
                          ? bus.wb_data : regs_reg[bus.decoded_rt_address];
            end
            if (wb_we) begin
                regs_reg[bus.wb_rd] <= bus.wb_data;
                busy_reg[bus.wb_rd] <= 1'b0;
            end
            // wb_ready guarantees wb_we and an UPDATE never target the same rd.
            if (upd_write) begin
                regs_reg[bus.decoded_rd_address] <= upd_data;
                busy_reg[bus.decoded_rd_address] <= 1'b0;
            end
            if (upd_defer) begin
                busy_reg[bus.decoded_rd_address] <= 1'b1;
            end
            regs_reg[NUM_REGS-3] <= DATA_BITS'(bus.block_id);
        end
    end

    assign bus.rs       = rs_reg;
    assign bus.rt       = rt_reg;
    assign bus.wb_ready = wb_ready_int;
    assign bus.hazard   = hazard_int;

endmodule

// File: tb/tb_thread_regfile.sv
// ---------------------------------------------------------------------------
// tb_thread_regfile
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural register-file model (plain arrays updated by the architectural
//   rules once per clock edge).
// ---------------------------------------------------------------------------
module tb_thread_regfile;
    localparam int NR  = 16;
    localparam int DB  = 8;
    localparam int AB  = 4;
    localparam int TPB = 4;
    localparam int TID = 2;

    localparam logic [2:0] REQ = 3'b011;
    localparam logic [2:0] UPD = 3'b110;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    thread_regfile_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    thread_regfile #(
        .NUM_REGS(NR), .DATA_BITS(DB), .THREADS_PER_BLOCK(TPB), .THREAD_ID(TID)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] m_regs [NR];
    bit         m_busy [NR];
    logic [7:0] m_rs;
    logic [7:0] m_rt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit can_write(int a);
`ifdef REGFILE_ZERO_REG_EN
        if (a == 0) return 1'b0;
`endif
        return a <= NR - 4;
    endfunction

    function automatic bit exp_wb_ready();
        return bus.enable && !(bus.core_state == UPD && bus.decoded_reg_write_enable
                               && bus.decoded_rd_address == bus.wb_rd);
    endfunction

    function automatic bit exp_hazard();
        return bus.enable && (m_busy[bus.decoded_rs_address] || m_busy[bus.decoded_rt_address]
                              || m_busy[bus.decoded_rd_address]);
    endfunction

    // Applies one clock edge of architectural behaviour to the model.
    task automatic model_edge();
        logic [7:0] nr [NR];
        bit         nb [NR];
        bit         acc;
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_regs[i] = 8'h00;
                m_busy[i] = 1'b0;
            end
            m_regs[NR-2] = 8'(TPB);
            m_regs[NR-1] = 8'(TID);
            m_rs = 8'h00;
            m_rt = 8'h00;
            return;
        end
        if (!bus.enable) return;
        nr  = m_regs;
        nb  = m_busy;
        acc = bus.wb_valid && exp_wb_ready() && can_write(int'(bus.wb_rd));
        if (bus.core_state == REQ) begin
            m_rs = (acc && bus.wb_rd == bus.decoded_rs_address) ? bus.wb_data
                   : m_regs[bus.decoded_rs_address];
            m_rt = (acc && bus.wb_rd == bus.decoded_rt_address) ? bus.wb_data
                   : m_regs[bus.decoded_rt_address];
        end
        if (acc) begin
            nr[bus.wb_rd] = bus.wb_data;
            nb[bus.wb_rd] = 1'b0;
        end
        if (bus.core_state == UPD && bus.decoded_reg_write_enable
            && can_write(int'(bus.decoded_rd_address))) begin
            case (bus.decoded_reg_input_mux)
                2'b00: begin nr[bus.decoded_rd_address] = bus.alu_out;           nb[bus.decoded_rd_address] = 1'b0; end
                2'b01: begin nr[bus.decoded_rd_address] = bus.lsu_out;           nb[bus.decoded_rd_address] = 1'b0; end
                2'b10: begin nr[bus.decoded_rd_address] = bus.decoded_immediate; nb[bus.decoded_rd_address] = 1'b0; end
                default: nb[bus.decoded_rd_address] = 1'b1;
            endcase
        end
        nr[NR-3] = bus.block_id;
        m_regs = nr;
        m_busy = nb;
    endtask

    // One cycle: check combinational outputs, clock, then check operands.
    task automatic tick();
        #1;
        check("wb_ready", {31'b0, bus.wb_ready}, {31'b0, exp_wb_ready()});
        check("hazard",   {31'b0, bus.hazard},   {31'b0, exp_hazard()});
        @(posedge clk);
        model_edge();
        #1;
        check("rs", {24'b0, bus.rs}, {24'b0, m_rs});
        check("rt", {24'b0, bus.rt}, {24'b0, m_rt});
    endtask

    task automatic idle();
        bus.enable                   = 1'b1;
        bus.core_state               = 3'b000;
        bus.decoded_reg_write_enable = 1'b0;
        bus.decoded_reg_input_mux    = 2'b00;
        bus.decoded_rd_address       = '0;
        bus.decoded_rs_address       = '0;
        bus.decoded_rt_address       = '0;
        bus.decoded_immediate        = '0;
        bus.alu_out                  = '0;
        bus.lsu_out                  = '0;
        bus.wb_valid                 = 1'b0;
        bus.wb_rd                    = '0;
        bus.wb_data                  = '0;
    endtask

    task automatic update(input logic [1:0] mux, input logic [3:0] rd, input logic [7:0] val);
        idle();
        bus.core_state               = UPD;
        bus.decoded_reg_write_enable = 1'b1;
        bus.decoded_reg_input_mux    = mux;
        bus.decoded_rd_address       = rd;
        bus.alu_out                  = val;
        bus.lsu_out                  = val;
        bus.decoded_immediate        = val;
    endtask

    task automatic request(input logic [3:0] rs, input logic [3:0] rt);
        idle();
        bus.core_state         = REQ;
        bus.decoded_rs_address = rs;
        bus.decoded_rt_address = rt;
    endtask

    initial begin
        logic [7:0] exp_r0;
        // Reset cycle (DUT state unknown before it, so checked after the edge).
        reset = 1'b1;
        idle();
        bus.block_id = 8'd5;
        @(posedge clk);
        model_edge();
        #1;
        check("reset_rs", {24'b0, bus.rs}, 32'h0);
        check("reset_rt", {24'b0, bus.rt}, 32'h0);
        reset = 1'b0;
        idle();
        #1;
        check("reset_hazard", {31'b0, bus.hazard}, 32'h0);
        tick();                                  // latch block_id into R13

        request(4'd13, 4'd15); tick();
        $display("txn special regs: rs=%0h rt=%0h", bus.rs, bus.rt);
        check("blockidx", {24'b0, bus.rs}, 32'h05);
        check("threadidx", {24'b0, bus.rt}, 32'h02);

        update(2'b10, 4'd3, 8'h2A); tick();
        request(4'd3, 4'd14); tick();
        $display("txn const write R3: rs=%0h", bus.rs);
        check("const_r3", {24'b0, bus.rs}, 32'h2A);

        update(2'b00, 4'd14, 8'hFF); tick();
        request(4'd14, 4'd3); tick();
        $display("txn readonly write R14: rs=%0h", bus.rs);
        check("ro_r14", {24'b0, bus.rs}, 32'h04);

        update(2'b11, 4'd4, 8'h00); tick();
        request(4'd4, 4'd0);
        #1;
        check("hazard_busy", {31'b0, bus.hazard}, 32'h1);
        idle();
        bus.wb_valid = 1'b1; bus.wb_rd = 4'd4; bus.wb_data = 8'h77;
        tick();
        request(4'd4, 4'd0);
        #1;
        check("hazard_clear", {31'b0, bus.hazard}, 32'h0);
        tick();
        $display("txn deferred load R4: rs=%0h", bus.rs);
        check("wb_r4", {24'b0, bus.rs}, 32'h77);

        request(4'd4, 4'd4);
        bus.wb_valid = 1'b1; bus.wb_rd = 4'd4; bus.wb_data = 8'h11;
        tick();
        $display("txn forward R4: rs=%0h rt=%0h", bus.rs, bus.rt);
        check("fwd_rs", {24'b0, bus.rs}, 32'h11);
        check("fwd_rt", {24'b0, bus.rt}, 32'h11);

        update(2'b00, 4'd6, 8'hAB);
        bus.wb_valid = 1'b1; bus.wb_rd = 4'd6; bus.wb_data = 8'h5C;
        #1;
        check("wb_blocked", {31'b0, bus.wb_ready}, 32'h0);
        tick();
        idle();
        bus.wb_valid = 1'b1; bus.wb_rd = 4'd6; bus.wb_data = 8'h5C;
        #1;
        check("wb_retry", {31'b0, bus.wb_ready}, 32'h1);
        tick();
        request(4'd6, 4'd6); tick();
        $display("txn wb after update R6: rs=%0h", bus.rs);
        check("wb_r6", {24'b0, bus.rs}, 32'h5C);

        update(2'b10, 4'd0, 8'h09); tick();
        request(4'd0, 4'd0); tick();
`ifdef REGFILE_ZERO_REG_EN
        exp_r0 = 8'h00;
`else
        exp_r0 = 8'h09;
`endif
        $display("txn write R0: rs=%0h", bus.rs);
        check("r0", {24'b0, bus.rs}, {24'b0, exp_r0});

        // Disabled thread: nothing changes, outputs quiet.
        update(2'b11, 4'd5, 8'h33);
        bus.enable = 1'b0;
        bus.decoded_rs_address = 4'd4;
        #1;
        check("dis_hazard", {31'b0, bus.hazard}, 32'h0);
        check("dis_wb_ready", {31'b0, bus.wb_ready}, 32'h0);
        tick();
        request(4'd5, 4'd5);
        #1;
        check("dis_no_busy", {31'b0, bus.hazard}, 32'h0);
        tick();
        check("dis_r5", {24'b0, bus.rs}, 32'h00);

        // Writeback to a read-only register: accepted, dropped.
        idle();
        bus.wb_valid = 1'b1; bus.wb_rd = 4'd15; bus.wb_data = 8'hEE;
        tick();
        request(4'd15, 4'd15); tick();
        check("ro_wb_r15", {24'b0, bus.rt}, 32'h02);

        // Reset while a load is outstanding.
        update(2'b11, 4'd7, 8'h00); tick();
        reset = 1'b1; idle(); tick();
        reset = 1'b0;
        request(4'd7, 4'd13);
        #1;
        check("reset_busy", {31'b0, bus.hazard}, 32'h0);
        tick();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int sel;
            reset = ($urandom_range(0, 79) == 0);
            sel   = int'($urandom_range(0, 3));
            bus.enable                   = ($urandom_range(0, 9) != 0);
            bus.core_state               = (sel == 0) ? REQ : (sel == 1) ? UPD : 3'($urandom_range(0, 7));
            bus.decoded_reg_write_enable = 1'($urandom);
            bus.decoded_reg_input_mux    = 2'($urandom);
            bus.decoded_rd_address       = 4'($urandom);
            bus.decoded_rs_address       = 4'($urandom);
            bus.decoded_rt_address       = 4'($urandom);
            bus.decoded_immediate        = 8'($urandom);
            bus.alu_out                  = 8'($urandom);
            bus.lsu_out                  = 8'($urandom);
            bus.wb_valid                 = ($urandom_range(0, 2) == 0);
            bus.wb_rd                    = 4'($urandom);
            bus.wb_data                  = 8'($urandom);
            if ($urandom_range(0, 15) == 0) bus.block_id = 8'($urandom);
            tick();
        end
        reset = 1'b0;

        // Final sweep of every register through the operand ports.
        for (int i = 0; i < NR; i++) begin
            request(4'(i), 4'(NR - 1 - i));
            tick();
            $display("txn sweep R%0d: rs=%0h rt=%0h", i, bus.rs, bus.rt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
